// File: rtl/ppm_eof_gen.sv
// PPM end-of-frame generator: on a rising edge of control_eof, shifts EOF_PATTERN out MSB
// first, one bit per SLOT_CYCLES-clock slot, then pulses eof_done for one cycle.
module ppm_eof_gen #(
  parameter int unsigned        SLOT_CYCLES = 16,
  parameter int unsigned        EOF_LEN     = 8,
  parameter logic [EOF_LEN-1:0] EOF_PATTERN = 8'b1011_0001
) (
  input  logic clk,
  input  logic rst_n,
  input  logic control_eof,
  output logic eof,
  output logic eof_done
);

  localparam int unsigned CycW  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned SlotW = (EOF_LEN > 1) ? $clog2(EOF_LEN) : 1;

  localparam logic [CycW-1:0]  CycLast  = CycW'(SLOT_CYCLES - 1);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(EOF_LEN - 1);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e             state_q, state_d;
  logic [CycW-1:0]    cyc_q, cyc_d;
  logic [SlotW-1:0]   slot_q, slot_d;
  logic               ctl_q;
  logic               eof_q, eof_d;
  logic               done_q, done_d;
  logic               start;

  // Edge detect: a level held high only ever produces one start.
  assign start = control_eof & ~ctl_q;

  // Next-state, slot/cycle counters and registered-output values.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    slot_d  = slot_q;
    eof_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSend;
          slot_d  = SlotLast;
          cyc_d   = '0;
        end
      end
      StSend: begin
        eof_d = EOF_PATTERN[slot_q];
        if (cyc_q == CycLast) begin
          cyc_d = '0;
          if (slot_q == '0) begin
            state_d = StDone;
          end else begin
            slot_d = slot_q - SlotW'(1);
          end
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters, request history and outputs; reset aborts any pattern at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      slot_q  <= '0;
      ctl_q   <= 1'b0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      slot_q  <= slot_d;
      ctl_q   <= control_eof;
      eof_q   <= eof_d;
      done_q  <= done_d;
    end
  end

  assign eof      = eof_q;
  assign eof_done = done_q;

endmodule

// File: tb/tb_ppm_eof_gen.sv
// Directed bench for ppm_eof_gen: default instance plus a small parameter override instance.
module tb_ppm_eof_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic ctl, ctl_s;
  logic eof, eof_done;
  logic eof_s, done_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ppm_eof_gen u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .control_eof (ctl),
    .eof         (eof),
    .eof_done    (eof_done)
  );

  ppm_eof_gen #(
    .SLOT_CYCLES (4),
    .EOF_LEN     (3),
    .EOF_PATTERN (3'b101)
  ) u_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .control_eof (ctl_s),
    .eof         (eof_s),
    .eof_done    (done_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Default pattern, k = clocks after the edge that sampled the request.
  function automatic logic exp_eof(int k);
    return (k >= 1 && k <= 16) || (k >= 33 && k <= 64) || (k >= 113 && k <= 128);
  endfunction

  // Override pattern 1111_0000_1111.
  function automatic logic exp_eof_s(int k);
    return (k >= 1 && k <= 4) || (k >= 9 && k <= 12);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    ctl   = 1'b0;
    ctl_s = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (eof !== 1'b0) begin bad++; $display("FAIL reset_eof cyc=%0d got=%b exp=0", i, eof); end
      total++;
      if (eof_done !== 1'b0) begin
        bad++; $display("FAIL reset_done cyc=%0d got=%b exp=0", i, eof_done);
      end
      total++;
      if (eof_s !== 1'b0) begin bad++; $display("FAIL reset_eof_s cyc=%0d got=%b exp=0", i, eof_s); end
      total++;
      if (done_s !== 1'b0) begin bad++; $display("FAIL reset_done_s cyc=%0d got=%b exp=0", i, done_s); end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (eof !== 1'b0 || eof_done !== 1'b0) begin
        bad++; $display("FAIL idle_after_reset cyc=%0d got=%b%b exp=00", i, eof, eof_done);
      end
    end
  endtask

  task automatic test_single_pulse();
    int ndone = 0;
    ctl = 1'b1;
    tick();
    ctl = 1'b0;
    for (int k = 0; k <= 135; k++) begin
      if (k > 0) tick();
      if (eof_done === 1'b1) ndone++;
      total++;
      if (eof !== exp_eof(k)) begin
        bad++; $display("FAIL pulse_eof k=%0d got=%b exp=%b", k, eof, exp_eof(k));
      end
      total++;
      if (eof_done !== (k == 129)) begin
        bad++; $display("FAIL pulse_done k=%0d got=%b exp=%b", k, eof_done, (k == 129));
      end
    end
    total++;
    if (ndone != 1) begin bad++; $display("FAIL pulse_done_count got=%0d exp=1", ndone); end
  endtask

  task automatic test_held_level();
    int ndone = 0;
    ctl = 1'b1;
    tick();
    for (int k = 0; k <= 300; k++) begin
      if (k > 0) tick();
      if (eof_done === 1'b1) ndone++;
      total++;
      if (eof !== exp_eof(k)) begin
        bad++; $display("FAIL held_eof k=%0d got=%b exp=%b", k, eof, exp_eof(k));
      end
      total++;
      if (eof_done !== (k == 129)) begin
        bad++; $display("FAIL held_done k=%0d got=%b exp=%b", k, eof_done, (k == 129));
      end
    end
    total++;
    if (ndone != 1) begin bad++; $display("FAIL held_done_count got=%0d exp=1", ndone); end
    ctl = 1'b0;
    tick();
    tick();
  endtask

  // New request raised the cycle the FSM returns to idle.
  task automatic test_back_to_back();
    ctl = 1'b1;
    tick();
    ctl = 1'b0;
    for (int k = 0; k <= 129; k++) begin
      if (k > 0) tick();
      total++;
      if (eof !== exp_eof(k) || eof_done !== (k == 129)) begin
        bad++; $display("FAIL b2b_first k=%0d got=%b%b exp=%b%b", k, eof, eof_done,
                        exp_eof(k), (k == 129));
      end
    end
    ctl = 1'b1;
    tick();
    ctl = 1'b0;
    for (int k = 0; k <= 132; k++) begin
      if (k > 0) tick();
      total++;
      if (eof !== exp_eof(k)) begin
        bad++; $display("FAIL b2b_second_eof k=%0d got=%b exp=%b", k, eof, exp_eof(k));
      end
      total++;
      if (eof_done !== (k == 129)) begin
        bad++; $display("FAIL b2b_second_done k=%0d got=%b exp=%b", k, eof_done, (k == 129));
      end
    end
  endtask

  task automatic test_ignored_pulse();
    int ndone = 0;
    ctl = 1'b1;
    tick();
    ctl = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (k > 0) tick();
      if (eof_done === 1'b1) ndone++;
      if (k <= 140) begin
        total++;
        if (eof !== exp_eof(k) || eof_done !== (k == 129)) begin
          bad++; $display("FAIL ignored_first k=%0d got=%b%b exp=%b%b", k, eof, eof_done,
                          exp_eof(k), (k == 129));
        end
      end else if (k % 50 == 0) begin
        total++;
        if (eof !== 1'b0 || eof_done !== 1'b0) begin
          bad++; $display("FAIL ignored_idle k=%0d got=%b%b exp=00", k, eof, eof_done);
        end
      end
      ctl = (k == 50);
    end
    total++;
    if (ndone != 1) begin bad++; $display("FAIL ignored_done_count got=%0d exp=1", ndone); end
    ctl = 1'b1;
    tick();
    ctl = 1'b0;
    for (int k = 0; k <= 132; k++) begin
      if (k > 0) tick();
      total++;
      if (eof !== exp_eof(k) || eof_done !== (k == 129)) begin
        bad++; $display("FAIL later_pattern k=%0d got=%b%b exp=%b%b", k, eof, eof_done,
                        exp_eof(k), (k == 129));
      end
    end
  endtask

  task automatic test_reset_abort();
    int ndone = 0;
    ctl = 1'b1;
    tick();
    ctl = 1'b0;
    for (int k = 1; k <= 40; k++) tick();
    total++;
    if (eof !== 1'b1) begin bad++; $display("FAIL abort_pre_eof got=%b exp=1", eof); end
    rst_n = 1'b0;
    #1;
    total++;
    if (eof !== 1'b0) begin bad++; $display("FAIL abort_async_eof got=%b exp=0", eof); end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (eof_done === 1'b1) ndone++;
      total++;
      if (eof !== 1'b0) begin bad++; $display("FAIL abort_idle_eof k=%0d got=%b exp=0", k, eof); end
    end
    total++;
    if (ndone != 0) begin bad++; $display("FAIL abort_done_count got=%0d exp=0", ndone); end
    ctl = 1'b1;
    tick();
    ctl = 1'b0;
    for (int k = 0; k <= 131; k++) begin
      if (k > 0) tick();
      total++;
      if (eof !== exp_eof(k) || eof_done !== (k == 129)) begin
        bad++; $display("FAIL abort_restart k=%0d got=%b%b exp=%b%b", k, eof, eof_done,
                        exp_eof(k), (k == 129));
      end
    end
  endtask

  task automatic test_param_override();
    ctl_s = 1'b1;
    tick();
    ctl_s = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) tick();
      total++;
      if (eof_s !== exp_eof_s(k)) begin
        bad++; $display("FAIL small_eof k=%0d got=%b exp=%b", k, eof_s, exp_eof_s(k));
      end
      total++;
      if (done_s !== (k == 13)) begin
        bad++; $display("FAIL small_done k=%0d got=%b exp=%b", k, done_s, (k == 13));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_held_level();
    test_back_to_back();
    test_ignored_pulse();
    test_reset_abort();
    test_param_override();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
